// File: rtl/bus_mux_pkg.sv
// bus_mux_pkg: shared constants and helpers for the bus_arb_mux slice.
//   MODE_FIXED / MODE_RR : values of the bus_arb_mux mode input.
//   slice_lo()           : low bit of channel idx in a flattened data bus.
package bus_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned slice_lo(input int unsigned idx,
                                             input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/bus_arb_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       : per-channel request vector
//   ptr       : last granted channel; the search starts at ptr+1
//   gnt_valid : some request was found
//   gnt_idx   : index of the granted channel
module rr_arbiter #(
    parameter  int NCH  = 16,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    logic [2*NCH-1:0] dbl;

    // Lower copy keeps only channels above ptr, upper copy keeps all of them,
    // so a plain lowest-first scan visits ptr+1 .. NCH-1, 0 .. ptr.
    always_comb begin
        dbl = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            dbl[i]       = req[i] && (SELW'(i) > ptr);
            dbl[NCH + i] = req[i];
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 0; i < 2 * NCH; i++) begin
            if (dbl[i] && !gnt_valid) begin
                gnt_valid = 1'b1;
                gnt_idx   = (i >= NCH) ? SELW'(i - NCH) : SELW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: NCH-channel valid/ready multiplexer onto one registered output.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : global enable for accepting new input
//   mode, sel       : 0 = fixed channel sel, 1 = round-robin
//   in_data/valid   : flattened channel data and per-channel valid
//   in_ready        : per-channel ready (one-hot or zero)
//   out_data/valid  : registered output, drained by out_ready
//   out_chan        : channel that supplied out_data
module bus_arb_mux
    import bus_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 16,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    logic [SELW-1:0]  rr_ptr;
    logic             rr_valid;
    logic [SELW-1:0]  rr_idx;
    logic             fix_valid;
    logic             granted;
    logic [SELW-1:0]  gnt;
    logic             load_ok;
    logic             transfer;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(.NCH(NCH)) u_rr (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    assign load_ok = !out_valid || out_ready;

    // Compare against every real channel so sel >= NCH simply matches nothing.
    always_comb begin
        fix_valid = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                fix_valid = 1'b1;
            end
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            granted = rr_valid;
            gnt     = rr_idx;
        end else begin
            granted = fix_valid;
            gnt     = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            in_ready[i] = !rst && en && load_ok && granted && (gnt == SELW'(i));
        end
    end

    // A grant always implies in_valid[gnt], so any ready bit is a handshake.
    assign transfer = |in_ready;

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = in_data[slice_lo(i, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            rr_ptr    <= SELW'(NCH - 1);
        end else if (load_ok) begin
            out_valid <= transfer;
            if (transfer) begin
                out_data <= gnt_data;
                out_chan <= gnt;
                if (mode == MODE_RR) begin
                    rr_ptr <= gnt;
                end
            end
        end
    end

endmodule

// File: doc/bus_arb_mux.md
Name: bus_arb_mux

Overview:
- Parametrised successor to the 8-bit, 16-input tristate bus mux.
- Selects one of NCH WIDTH-bit input channels onto a single registered output, using either an explicit select (fixed mode) or round-robin arbitration.
- Per-channel valid/ready handshakes on the inputs; a valid/ready handshake on the output.
- Sits between RAM bank read ports / peripheral sources and the shared byte bus. Replaces tristate gating with a clean enable and back-pressure.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- NCH, 16, number of input channels (2..64; need not be a power of two).
- SELW, $clog2(NCH), select/channel-index width. Derived; never overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable. When low, no new input is accepted; any held output still drains.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_data  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational, one-hot or zero).
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_chan  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, synchronous release):
  - out_data = 0, out_valid = 0, out_chan = 0.
  - Round-robin pointer rr_ptr = NCH-1, so the first search starts at channel 0.
- Load condition: load_ok = !out_valid || out_ready (single-entry output register; full throughput when out_ready is held high).
- Grant, fixed mode (mode = 0):
  - gnt = sel, granted only if sel < NCH and in_valid[sel].
  - sel >= NCH means no grant; this is not an error.
- Grant, round-robin mode (mode = 1):
  - Search channels rr_ptr+1, rr_ptr+2, ... with wrap modulo NCH.
  - The first channel with in_valid set is granted.
  - rr_ptr itself is searched last.
- Ready: in_ready[i] = en && load_ok && granted && (gnt == i). At most one bit is set.
- Transfer (in_valid[gnt] && in_ready[gnt]):
  - Next edge: out_data <= channel gnt data, out_chan <= gnt, out_valid <= 1.
  - In mode 1 only: rr_ptr <= gnt. In mode 0, rr_ptr is unchanged.
- No transfer while load_ok: out_valid <= 0. out_data and out_chan hold their last values.
- Stall (out_valid && !out_ready):
  - The output register holds.
  - All in_ready are low.
  - Inputs must hold data while valid (standard valid/ready rules).
- Latency: 1 cycle from input handshake to out_valid.
- Simultaneous drain and load: when out_ready = 1 and a new transfer occurs in the same cycle, out_valid stays 1 and the new data replaces the old with no bubble.
- en deassert:
  - Takes effect combinationally on in_ready.
  - A pending output still completes.
  - rr_ptr is frozen.
- Mode or sel change mid-stream: applies to the next grant decision only. Held output data is unaffected.
- Reset mid-operation: output is discarded immediately. in_ready goes low while rst is high.
- Single valid channel in round-robin mode: it is granted every cycle, including when it equals rr_ptr.

Decomposition:
- Package bus_mux_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - A function for the flattened slice index.
- Sub-module rr_arbiter (parameter NCH):
  - Inputs: req[NCH], ptr[SELW]. Outputs: gnt_valid, gnt_idx[SELW].
  - Purely combinational, implemented as a double-width masked priority encoder.
- bus_arb_mux holds the pointer, the output register and the handshake logic.

Test Plan:
- Reset with all in_valid high:
  - out_valid = 0 and in_ready = 0 while rst = 1.
  - After release in mode 1, the first grant is channel 0.
- Mode 0, sel = 5, in_valid = 16'h0020, data5 = 8'hA5, out_ready = 1 -> in_ready = 16'h0020; next cycle out_data = A5, out_chan = 5, out_valid = 1.
- Mode 1, in_valid = 16'hFFFF, out_ready = 1 for 20 cycles -> out_chan sequence 0,1,...,15,0,1,2,3 with one transfer per cycle.
- Stall: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data and out_chan held and in_ready = 0; on out_ready = 1, the next grant is taken the same cycle with no bubble.
- en = 0 while out_valid = 1 -> the held byte drains when out_ready = 1, then out_valid = 0, with no further grants until en = 1.
- NCH = 5 build, mode 0, sel = 7 -> no grant and in_ready = 0; in mode 1 with in_valid = 5'b10001 after a grant to channel 4 -> the next grant is channel 0 (wrap).
